// File: rtl/bus_arbiter_rr_if.sv
// Bus arbitration handshake bundle between the bus masters and bus_arbiter_rr.
//   m_req_    per-master request, active-low (bit i = master i)
//   m_grnt_   per-master grant, active-low, exactly one bit low
//   owner     index of the current bus owner
//   bus_busy  high while the current owner is still requesting
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
);
    logic [NUM_MASTERS-1:0] m_req_;
    logic [NUM_MASTERS-1:0] m_grnt_;
    logic [OWNER_W-1:0]     owner;
    logic                   bus_busy;

    modport master (
        output m_req_,
        input  m_grnt_,
        input  owner,
        input  bus_busy
    );

    modport slave (
        input  m_req_,
        output m_grnt_,
        output owner,
        output bus_busy
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Non-preemptive round-robin arbiter for the shared system bus.
// The owner keeps the bus while its request is held low. When it releases, the
// next requester after it in rotation takes over one edge later; with no
// requester the grant stays parked on the last owner.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; parks the bus on master 0
//   bus    arbitration bundle (slave side): m_req_ in, m_grnt_/owner/bus_busy out
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_rr_if.slave   bus
);

    logic [OWNER_W-1:0]       owner_q;
    logic [OWNER_W-1:0]       owner_nxt;
    logic [NUM_MASTERS-1:0]   grnt_q;
    logic [NUM_MASTERS-1:0]   req_act;
    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-2:0]   req_rot;
    logic                     owner_legal;
    logic                     owner_req;

    // A request bit counts as released only when it is a clean 1, so an
    // unknown level never lets the current owner lose the bus by accident.
    always_comb begin
        req_act = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req_act[i] = (bus.m_req_[i] !== 1'b1);
        end
    end

    // Encodings at or above NUM_MASTERS are unreachable in normal operation;
    // they are flagged here and steered back to master 0.
    always_comb begin
        owner_legal = 1'b0;
        owner_req   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                owner_legal = 1'b1;
                owner_req   = req_act[i];
            end
        end
    end

    // Doubling the request vector and shifting by owner+1 lines the other
    // masters up in rotation order: bit k-1 of req_rot is master owner+k.
    always_comb begin
        req_dbl = {req_act, req_act};
        req_rot = (NUM_MASTERS-1)'(req_dbl >> (int'(owner_q) + 1));
    end

    always_comb begin : next_owner
        logic found;
        int   cand;
        owner_nxt = owner_q;
        found     = 1'b0;
        cand      = 0;
        if (!owner_legal) begin
            owner_nxt = '0;
        end else if (!owner_req) begin
            for (int k = 1; k < NUM_MASTERS; k++) begin
                cand = int'(owner_q) + k;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
                if (!found && req_rot[k-1]) begin
                    found     = 1'b1;
                    owner_nxt = OWNER_W'(cand);
                end
            end
        end
    end

    // Grant is decoded from the next owner so it switches on the same edge
    // as the owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '0;
            grnt_q  <= {{(NUM_MASTERS-1){1'b1}}, 1'b0};
        end else begin
            owner_q <= owner_nxt;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grnt_q[i] <= (owner_nxt != OWNER_W'(i));
            end
        end
    end

    assign bus.m_grnt_  = grnt_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = owner_req;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: a 4-master and a 3-master instance
// share clock and reset. Each driven cycle pushes the reference model's
// expected owner into a scoreboard; a monitor pops and compares after each edge.
module tb_bus_arbiter_rr;

    logic clk;
    logic reset;

    bus_arbiter_rr_if #(.NUM_MASTERS(4), .OWNER_W(2)) bif4 ();
    bus_arbiter_rr_if #(.NUM_MASTERS(3), .OWNER_W(2)) bif3 ();

    bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif4)
    );

    bus_arbiter_rr #(.NUM_MASTERS(3), .OWNER_W(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         o4;
        logic [3:0] r4;
        int         o3;
        logic [2:0] r3;
    } exp_t;

    exp_t sb_q[$];
    int   rec_q[$];
    logic rec_on = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_own4 = 0;
    int   m_own3 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: hold while the owner requests, otherwise the first requester
    // found walking forward from the owner (mod n); nobody requesting = stay.
    function automatic int model_next(input int own, input logic [7:0] req, input int n,
                                      input logic rst);
        if (rst) return 0;
        if (req[own] == 1'b0) return own;
        for (int k = 1; k < n; k++) begin
            if (req[(own + k) % n] == 1'b0) return (own + k) % n;
        end
        return own;
    endfunction

    function automatic logic [31:0] grant_of(input int own, input int n);
        logic [31:0] g;
        g = '0;
        for (int i = 0; i < n; i++) g[i] = (i != own);
        return g;
    endfunction

    task automatic cyc(input logic rst, input logic [3:0] r4, input logic [2:0] r3);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        bif4.m_req_ = r4;
        bif3.m_req_ = r3;
        m_own4 = model_next(m_own4, {4'hF, r4}, 4, rst);
        m_own3 = model_next(m_own3, {5'h1F, r3}, 3, rst);
        e.o4 = m_own4;
        e.r4 = r4;
        e.o3 = m_own3;
        e.r3 = r3;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("owner4", 32'(bif4.owner), mon_e.o4);
            chk("grant4", 32'(bif4.m_grnt_), grant_of(mon_e.o4, 4));
            chk("busy4", 32'(bif4.bus_busy), 32'(mon_e.r4[mon_e.o4] == 1'b0));
            chk("owner3", 32'(bif3.owner), mon_e.o3);
            chk("grant3", 32'(bif3.m_grnt_), grant_of(mon_e.o3, 3));
            chk("busy3", 32'(bif3.bus_busy), 32'(mon_e.r3[mon_e.o3] == 1'b0));
            chk("onehot3", $countones(~bif3.m_grnt_), 1);
        end
        if (rec_on) rec_q.push_back(int'(bif4.owner));
    end

    initial begin : main
        int          held;
        int          prev;
        int          order[$];
        int          exp_order[5];
        logic [3:0]  r4;
        logic [2:0]  r3;
        int          w;

        reset       = 1'b1;
        bif4.m_req_ = 4'b1111;
        bif3.m_req_ = 3'b111;

        // reset parks the bus on master 0
        repeat (3) cyc(1'b1, 4'b1111, 3'b111);
        #2;
        chk("rst_owner", 32'(bif4.owner), 0);
        chk("rst_grant", 32'(bif4.m_grnt_), 32'h0000_000E);
        chk("rst_busy", 32'(bif4.bus_busy), 0);

        // master 2 requests from park, then holds
        cyc(1'b0, 4'b1011, 3'b111);
        #2;
        chk("req2_owner", 32'(bif4.owner), 2);
        chk("req2_grant", 32'(bif4.m_grnt_), 32'h0000_000B);
        repeat (5) cyc(1'b0, 4'b1011, 3'b111);
        #2;
        chk("hold2_grant", 32'(bif4.m_grnt_), 32'h0000_000B);
        chk("hold2_busy", 32'(bif4.bus_busy), 1);

        // all request; each owner drops 3 cycles after its grant
        cyc(1'b1, 4'b0000, 3'b111);
        rec_on = 1'b1;
        held = 0;
        for (int c = 0; c < 17; c++) begin
            r4 = 4'b0000;
            if (held >= 3) r4[m_own4] = 1'b1;
            prev = m_own4;
            cyc(1'b0, r4, 3'b111);
            if (m_own4 != prev) held = 0;
            else held++;
        end
        #2;
        rec_on = 1'b0;
        foreach (rec_q[i]) begin
            if (order.size() == 0 || order[$] != rec_q[i]) order.push_back(rec_q[i]);
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_order_len", 32'(order.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) chk("rr_order", order[i], exp_order[i]);
        end

        // wrap-around: owner 3 releases with 0 and 2 requesting
        cyc(1'b0, 4'b0111, 3'b111);
        cyc(1'b0, 4'b0111, 3'b111);
        #2;
        chk("wrap_owner3", 32'(bif4.owner), 3);
        cyc(1'b0, 4'b1010, 3'b111);
        #2;
        chk("wrap_owner0", 32'(bif4.owner), 0);
        cyc(1'b0, 4'b1011, 3'b111);
        #2;
        chk("wrap_owner2", 32'(bif4.owner), 2);

        // reset mid-tenure of master 1
        cyc(1'b0, 4'b1101, 3'b111);
        #2;
        chk("mid_owner1", 32'(bif4.owner), 1);
        cyc(1'b1, 4'b1101, 3'b111);
        #2;
        chk("mid_rst_owner", 32'(bif4.owner), 0);
        chk("mid_rst_grant", 32'(bif4.m_grnt_), 32'h0000_000E);
        cyc(1'b0, 4'b1101, 3'b111);
        #2;
        chk("mid_regrant", 32'(bif4.owner), 1);

        // 3-master instance: 2 then 1 only
        cyc(1'b0, 4'b1111, 3'b011);
        #2;
        chk("n3_owner2", 32'(bif3.owner), 2);
        cyc(1'b0, 4'b1111, 3'b101);
        #2;
        chk("n3_owner1", 32'(bif3.owner), 1);
        chk("n3_grant1", 32'(bif3.m_grnt_), 32'h0000_0005);

        // random traffic with held patterns and sparse resets
        for (int c = 0; c < 120; c++) begin
            r4 = 4'($urandom_range(0, 15));
            r3 = 3'($urandom_range(0, 7));
            for (int h = $urandom_range(1, 4); h > 0; h--) begin
                cyc(($urandom_range(0, 39) == 0), r4, r3);
            end
        end

        w = 0;
        while (sb_q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        chk("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
